// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: unit select, per-unit op codes,
// compare result codes and one-hot unit tags.
package alu_pkg;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } unit_e;

    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB      = 2'b01;
    localparam logic [1:0] OP_MUL      = 2'b10;
    localparam logic [1:0] OP_DIV      = 2'b11;

    localparam logic [1:0] OP_AND      = 2'b00;
    localparam logic [1:0] OP_OR       = 2'b01;
    localparam logic [1:0] OP_NAND     = 2'b10;
    localparam logic [1:0] OP_NOR      = 2'b11;

    localparam logic [1:0] OP_EQ       = 2'b00;
    localparam logic [1:0] OP_GT       = 2'b01;
    localparam logic [1:0] OP_LT       = 2'b10;
    localparam logic [1:0] OP_CMP_NONE = 2'b11;

    localparam logic [1:0] OP_SRL_A    = 2'b00;
    localparam logic [1:0] OP_SLL_A    = 2'b01;
    localparam logic [1:0] OP_SRL_B    = 2'b10;
    localparam logic [1:0] OP_SLL_B    = 2'b11;

    localparam logic [1:0] CMP_EQ      = 2'd1;
    localparam logic [1:0] CMP_GT      = 2'd2;
    localparam logic [1:0] CMP_LT      = 2'd3;

    localparam logic [3:0] UF_ARITH    = 4'b0001;
    localparam logic [3:0] UF_LOGIC    = 4'b0010;
    localparam logic [3:0] UF_CMP      = 4'b0100;
    localparam logic [3:0] UF_SHIFT    = 4'b1000;

endpackage

// File: rtl/alu_pipelined_if.sv
// Operand/result bus of the pipelined ALU with valid/ready handshakes on both
// sides. master = producer/consumer side, slave = the ALU.
interface alu_pipelined_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 2 * WIDTH
);
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [3:0]           ALU_FUN;
    logic                 In_Valid;
    logic                 In_Ready;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic [OUT_WIDTH-1:0] Result;
    logic [3:0]           Unit_Flag;
    logic                 Err_Flag;

    modport master (
        output A, B, ALU_FUN, In_Valid, Out_Ready,
        input  In_Ready, Out_Valid, Result, Unit_Flag, Err_Flag
    );

    modport slave (
        input  A, B, ALU_FUN, In_Valid, Out_Ready,
        output In_Ready, Out_Valid, Result, Unit_Flag, Err_Flag
    );
endinterface

// File: rtl/alu_exec.sv
// Combinational ALU datapath: signed arith, logic, compare and shift units.
// The arith divider is only built when ALU_PIPELINED_DIV_EN is defined.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           alu_fun,
    output logic [OUT_WIDTH-1:0] result,
    output logic [3:0]           unit_flag,
    output logic                 err_flag
);
    logic signed [OUT_WIDTH-1:0] a_s;
    logic signed [OUT_WIDTH-1:0] b_s;
    logic [WIDTH-1:0]            narrow;
    logic [1:0]                  cmp_code;
    logic [1:0]                  op;
    unit_e                       unit;

    assign a_s  = {{(OUT_WIDTH-WIDTH){a[WIDTH-1]}}, a};
    assign b_s  = {{(OUT_WIDTH-WIDTH){b[WIDTH-1]}}, b};
    assign op   = alu_fun[1:0];
    assign unit = unit_e'(alu_fun[3:2]);

    // Non-arith units work at operand width and are zero-extended afterwards
    always_comb begin
        result    = '0;
        unit_flag = '0;
        err_flag  = 1'b0;
        narrow    = '0;
        cmp_code  = 2'b00;
        case (unit)
            UNIT_ARITH: begin
                unit_flag = UF_ARITH;
                case (op)
                    OP_ADD: result = a_s + b_s;
                    OP_SUB: result = a_s - b_s;
                    OP_MUL: result = a_s * b_s;
                    OP_DIV: begin
`ifdef ALU_PIPELINED_DIV_EN
                        if (b_s == '0) err_flag = 1'b1;
                        else           result   = a_s / b_s;
`else
                        err_flag = 1'b1;
`endif
                    end
                endcase
            end
            UNIT_LOGIC: begin
                unit_flag = UF_LOGIC;
                case (op)
                    OP_AND:  narrow = a & b;
                    OP_OR:   narrow = a | b;
                    OP_NAND: narrow = ~(a & b);
                    OP_NOR:  narrow = ~(a | b);
                endcase
                result = {{(OUT_WIDTH-WIDTH){1'b0}}, narrow};
            end
            UNIT_CMP: begin
                unit_flag = UF_CMP;
                case (op)
                    OP_EQ:       cmp_code = (a_s == b_s) ? CMP_EQ : 2'b00;
                    OP_GT:       cmp_code = (a_s > b_s)  ? CMP_GT : 2'b00;
                    OP_LT:       cmp_code = (a_s < b_s)  ? CMP_LT : 2'b00;
                    OP_CMP_NONE: cmp_code = 2'b00;
                endcase
                result = {{(OUT_WIDTH-2){1'b0}}, cmp_code};
            end
            UNIT_SHIFT: begin
                unit_flag = UF_SHIFT;
                case (op)
                    OP_SRL_A: narrow = a >> 1;
                    OP_SLL_A: narrow = a << 1;
                    OP_SRL_B: narrow = b >> 1;
                    OP_SLL_B: narrow = b << 1;
                endcase
                result = {{(OUT_WIDTH-WIDTH){1'b0}}, narrow};
            end
        endcase
    end
endmodule

// File: rtl/alu_pipelined.sv
// Two-stage pipelined ALU: stage 1 holds operands, stage 2 holds the result.
// Optional divider enabled by ALU_PIPELINED_DIV_EN (see alu_exec).
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    alu_pipelined_if.slave bus
);
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    logic [3:0]           s1_fun_q, s1_fun_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] s2_result_q, s2_result_d;
    logic [3:0]           s2_unit_q, s2_unit_d;
    logic                 s2_err_q, s2_err_d;

    logic                 in_fire, out_fire, s2_load;
    logic [OUT_WIDTH-1:0] exec_result;
    logic [3:0]           exec_unit;
    logic                 exec_err;

    alu_exec #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_exec (
        .a         (s1_a_q),
        .b         (s1_b_q),
        .alu_fun   (s1_fun_q),
        .result    (exec_result),
        .unit_flag (exec_unit),
        .err_flag  (exec_err)
    );

    // Only stall upstream when both stages are full and the result is not leaving
    assign bus.In_Ready = RST && !(s1_valid_q && s2_valid_q && !bus.Out_Ready);
    assign in_fire      = bus.In_Valid && bus.In_Ready;
    assign out_fire     = s2_valid_q && bus.Out_Ready;
    assign s2_load      = s1_valid_q && (!s2_valid_q || bus.Out_Ready);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_fun_d    = s1_fun_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_unit_d   = s2_unit_q;
        s2_err_d    = s2_err_q;
        if (s2_load) begin
            s2_valid_d  = 1'b1;
            s2_result_d = exec_result;
            s2_unit_d   = exec_unit;
            s2_err_d    = exec_err;
        end else if (out_fire) begin
            s2_valid_d  = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.A;
            s1_b_d     = bus.B;
            s1_fun_d   = bus.ALU_FUN;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_fun_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_unit_q   <= '0;
            s2_err_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_fun_q    <= s1_fun_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_unit_q   <= s2_unit_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign bus.Out_Valid = s2_valid_q;
    assign bus.Result    = s2_result_q;
    assign bus.Unit_Flag = s2_valid_q ? s2_unit_q : 4'b0000;
    assign bus.Err_Flag  = s2_valid_q && s2_err_q;
endmodule

// File: tb/tb_alu_pipelined.sv
// Directed bench for alu_pipelined (WIDTH=16); division expectations follow
// ALU_PIPELINED_DIV_EN.
module tb_alu_pipelined;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [3:0]  t_fun  [32];
    logic [15:0] t_a    [32];
    logic [15:0] t_b    [32];
    logic [31:0] t_res  [32];
    logic [3:0]  t_unit [32];
    logic        t_err  [32];
    int          n_ops = 0;

    alu_pipelined_if #(.WIDTH(16)) bus ();
    alu_pipelined #(.WIDTH(16)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] r, input logic [3:0] u, input logic e);
        t_fun[n_ops] = f; t_a[n_ops] = a; t_b[n_ops] = b;
        t_res[n_ops] = r; t_unit[n_ops] = u; t_err[n_ops] = e;
        n_ops++;
    endtask

    // One op offered per cycle with Out_Ready=1; result i must appear in cycle i+2
    task automatic run_stream();
        for (int i = 0; i < n_ops + 2; i++) begin
            if (i < n_ops) begin
                bus.In_Valid = 1'b1;
                bus.ALU_FUN  = t_fun[i];
                bus.A        = t_a[i];
                bus.B        = t_b[i];
            end else begin
                bus.In_Valid = 1'b0;
            end
            #1;
            if (i < n_ops) chk($sformatf("in_ready_%0d", i), bus.In_Ready, 1'b1);
            if (i < 2) begin
                chk($sformatf("latency_valid_%0d", i), bus.Out_Valid, 1'b0);
            end else begin
                chk($sformatf("valid_%0d", i-2), bus.Out_Valid, 1'b1);
                chk($sformatf("result_%0d", i-2), bus.Result, t_res[i-2]);
                chk($sformatf("unit_%0d", i-2), bus.Unit_Flag, t_unit[i-2]);
                chk($sformatf("err_%0d", i-2), bus.Err_Flag, t_err[i-2]);
            end
            tick();
        end
        #1;
        chk("stream_drained", bus.Out_Valid, 1'b0);
        chk("stream_unit_zero", bus.Unit_Flag, 4'b0000);
    endtask

    initial begin
        rst           = 1'b0;
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALU_FUN   = '0;
        tick();
        tick();
        chk("rst_in_ready", bus.In_Ready, 1'b0);
        chk("rst_out_valid", bus.Out_Valid, 1'b0);
        chk("rst_result", bus.Result, 32'h0);
        chk("rst_unit", bus.Unit_Flag, 4'b0000);
        chk("rst_err", bus.Err_Flag, 1'b0);

        // Release and immediately offer -3 * 5
        rst = 1'b1;
        bus.In_Valid = 1'b1; bus.ALU_FUN = 4'b0010; bus.A = -16'sd3; bus.B = 16'sd5;
        #1;
        chk("post_rst_in_ready", bus.In_Ready, 1'b1);
        tick();
        bus.In_Valid = 1'b0;
        #1;
        chk("mul_latency_1", bus.Out_Valid, 1'b0);
        tick();
        chk("mul_valid", bus.Out_Valid, 1'b1);
        chk("mul_result", bus.Result, 32'hFFFF_FFF1);
        chk("mul_unit", bus.Unit_Flag, 4'b0001);
        chk("mul_err", bus.Err_Flag, 1'b0);
        tick();
        chk("mul_consumed", bus.Out_Valid, 1'b0);
        chk("mul_unit_cleared", bus.Unit_Flag, 4'b0000);

        // Back-to-back stream covering every unit/op
        add_op(4'b1000, 16'd7,     16'd7,     32'h0000_0001, 4'b0100, 1'b0);
        add_op(4'b0100, 16'hF0F0,  16'h0FF0,  32'h0000_00F0, 4'b0010, 1'b0);
        add_op(4'b1111, 16'h0000,  16'h8001,  32'h0000_0002, 4'b1000, 1'b0);
        add_op(4'b0000, 16'h7FFF,  16'h7FFF,  32'h0000_FFFE, 4'b0001, 1'b0);
        add_op(4'b0001, 16'h8000,  16'h0001,  32'hFFFF_7FFF, 4'b0001, 1'b0);
        add_op(4'b0010, 16'h8000,  16'h8000,  32'h4000_0000, 4'b0001, 1'b0);
        add_op(4'b0101, 16'hF0F0,  16'h0FF0,  32'h0000_FFF0, 4'b0010, 1'b0);
        add_op(4'b0110, 16'hF0F0,  16'h0FF0,  32'h0000_FF0F, 4'b0010, 1'b0);
        add_op(4'b0111, 16'hF0F0,  16'h0FF0,  32'h0000_000F, 4'b0010, 1'b0);
        add_op(4'b1001, 16'd5,     16'hFFFE,  32'h0000_0002, 4'b0100, 1'b0);
        add_op(4'b1001, 16'hFFFF,  16'h0001,  32'h0000_0000, 4'b0100, 1'b0);
        add_op(4'b1010, 16'hFFFF,  16'h0001,  32'h0000_0003, 4'b0100, 1'b0);
        add_op(4'b1011, 16'd1,     16'd2,     32'h0000_0000, 4'b0100, 1'b0);
        add_op(4'b1000, 16'd7,     16'd8,     32'h0000_0000, 4'b0100, 1'b0);
        add_op(4'b1100, 16'h8001,  16'h0000,  32'h0000_4000, 4'b1000, 1'b0);
        add_op(4'b1101, 16'hC001,  16'h0000,  32'h0000_8002, 4'b1000, 1'b0);
        add_op(4'b1110, 16'h1234,  16'h8001,  32'h0000_4000, 4'b1000, 1'b0);
        add_op(4'b0011, 16'd100,   16'd0,     32'h0000_0000, 4'b0001, 1'b1);
`ifdef ALU_PIPELINED_DIV_EN
        add_op(4'b0011, 16'hFF9C,  16'd7,     32'hFFFF_FFF2, 4'b0001, 1'b0);
        add_op(4'b0011, 16'h8000,  16'hFFFF,  32'h0000_8000, 4'b0001, 1'b0);
        add_op(4'b0011, 16'd7,     16'hFFFE,  32'hFFFF_FFFD, 4'b0001, 1'b0);
`else
        add_op(4'b0011, 16'hFF9C,  16'd7,     32'h0000_0000, 4'b0001, 1'b1);
        add_op(4'b0011, 16'h8000,  16'hFFFF,  32'h0000_0000, 4'b0001, 1'b1);
        add_op(4'b0011, 16'd7,     16'hFFFE,  32'h0000_0000, 4'b0001, 1'b1);
`endif
        run_stream();

        // Backpressure: Out_Ready low for 5 cycles while 3 ops are offered
        bus.Out_Ready = 1'b0;
        bus.In_Valid = 1'b1; bus.ALU_FUN = 4'b0000; bus.A = 16'd1; bus.B = 16'd2;
        #1;
        chk("bp_ready_c0", bus.In_Ready, 1'b1);
        tick();
        bus.ALU_FUN = 4'b0001; bus.A = 16'd10; bus.B = 16'd3;
        #1;
        chk("bp_ready_c1", bus.In_Ready, 1'b1);
        tick();
        bus.ALU_FUN = 4'b0101; bus.A = 16'h00F0; bus.B = 16'h0F00;
        for (int c = 2; c < 5; c++) begin
            #1;
            chk($sformatf("bp_stall_ready_c%0d", c), bus.In_Ready, 1'b0);
            chk($sformatf("bp_hold_valid_c%0d", c), bus.Out_Valid, 1'b1);
            chk($sformatf("bp_hold_result_c%0d", c), bus.Result, 32'h0000_0003);
            chk($sformatf("bp_hold_unit_c%0d", c), bus.Unit_Flag, 4'b0001);
            tick();
        end
        bus.Out_Ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.In_Ready, 1'b1);
        chk("bp_first_result", bus.Result, 32'h0000_0003);
        tick();
        bus.In_Valid = 1'b0;
        #1;
        chk("bp_second_valid", bus.Out_Valid, 1'b1);
        chk("bp_second_result", bus.Result, 32'h0000_0007);
        tick();
        chk("bp_third_valid", bus.Out_Valid, 1'b1);
        chk("bp_third_result", bus.Result, 32'h0000_0FF0);
        chk("bp_third_unit", bus.Unit_Flag, 4'b0010);
        tick();
        chk("bp_drained", bus.Out_Valid, 1'b0);

        // Reset with two ops in flight discards both
        bus.Out_Ready = 1'b0;
        bus.In_Valid = 1'b1; bus.ALU_FUN = 4'b0000; bus.A = 16'd5; bus.B = 16'd6;
        tick();
        bus.ALU_FUN = 4'b0100; bus.A = 16'hFFFF; bus.B = 16'h00FF;
        tick();
        bus.In_Valid = 1'b0;
        #1;
        chk("rst_mid_valid_before", bus.Out_Valid, 1'b1);
        rst = 1'b0;
        tick();
        chk("rst_mid_valid", bus.Out_Valid, 1'b0);
        chk("rst_mid_unit", bus.Unit_Flag, 4'b0000);
        chk("rst_mid_in_ready", bus.In_Ready, 1'b0);
        rst = 1'b1;
        bus.Out_Ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rst_no_ghost_%0d", c), bus.Out_Valid, 1'b0);
            tick();
        end
        n_ops = 0;
        add_op(4'b1010, 16'd3, 16'd9, 32'h0000_0003, 4'b0100, 1'b0);
        run_stream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
